// File: rtl/collision_scanner.sv
// Mario-vs-barrel hitbox checker: snapshot on start, then one barrel slot tested per clock.
// Latency: start sampled in cycle 0, slot i tested in cycle i+1, done pulses in cycle NUM_BARRELS+1.
// Backpressure: none; start is accepted only in IDLE and ignored while a scan is in flight.
//
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   start               frame tick; requests a scan of all barrel slots
//   mario_x, mario_y    Mario centre X / top Y
//   barrel_x, barrel_y  flat slot coordinates, slot i at [i*COORD_W +: COORD_W]
//   barrel_active       per-slot live flag; inactive slots never hit
//   busy, done          scan in progress / one-cycle result-valid pulse
//   collision           registered hit result, held until the next scan completes
//   hit_mask, hit_index raw per-slot hit bits and lowest hitting slot (0 if none)
//
// Optional feature: define COLLISION_GRACE_EN to add invincibility frames; after a
// reported hit, the next GRACE_FRAMES scans report collision=0.
module collision_scanner #(
    parameter int NUM_BARRELS  = 4,
    parameter int COORD_W      = 10,
    parameter int MARIO_HALF_W = 6,
    parameter int MARIO_H      = 15,
    parameter int BARREL_HALF  = 9,
    parameter int GRACE_FRAMES = 8,
    localparam int IDX_W       = (NUM_BARRELS > 1) ? $clog2(NUM_BARRELS) : 1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           start,
    input  logic [COORD_W-1:0]             mario_x,
    input  logic [COORD_W-1:0]             mario_y,
    input  logic [NUM_BARRELS*COORD_W-1:0] barrel_x,
    input  logic [NUM_BARRELS*COORD_W-1:0] barrel_y,
    input  logic [NUM_BARRELS-1:0]         barrel_active,
    output logic                           busy,
    output logic                           done,
    output logic                           collision,
    output logic [NUM_BARRELS-1:0]         hit_mask,
    output logic [IDX_W-1:0]               hit_index
);

    // Two guard bits: one so the +offsets cannot overflow, one for the sign so
    // that centre-minus-half-size goes negative instead of wrapping.
    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] MHW = SW'(MARIO_HALF_W);
    localparam logic signed [SW-1:0] MH  = SW'(MARIO_H);
    localparam logic signed [SW-1:0] BH  = SW'(BARREL_HALF);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                         state, state_nxt;
    logic [IDX_W-1:0]               idx;
    logic                           last_slot;
    logic [COORD_W-1:0]             snap_mx, snap_my;
    logic [NUM_BARRELS*COORD_W-1:0] snap_bx, snap_by;
    logic [NUM_BARRELS-1:0]         snap_act;
    logic [NUM_BARRELS-1:0]         work_mask, mask_final;
    logic [COORD_W-1:0]             cur_bx, cur_by;
    logic signed [SW-1:0]           m_xmin, m_xmax, m_ymin, m_ymax;
    logic signed [SW-1:0]           b_xmin, b_xmax, b_ymin, b_ymax;
    logic                           cur_hit;
    logic [IDX_W-1:0]               low_idx;
    logic                           enter_done;

    assign last_slot  = (idx == IDX_W'(NUM_BARRELS - 1));
    assign enter_done = (state == SCAN) && last_slot;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (last_slot) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bounds of Mario and of the slot under test, all in signed SW-bit space
    assign cur_bx = snap_bx[int'(idx)*COORD_W +: COORD_W];
    assign cur_by = snap_by[int'(idx)*COORD_W +: COORD_W];
    assign m_xmin = $signed({2'b00, snap_mx}) - MHW;
    assign m_xmax = $signed({2'b00, snap_mx}) + MHW;
    assign m_ymin = $signed({2'b00, snap_my});
    assign m_ymax = $signed({2'b00, snap_my}) + MH;
    assign b_xmin = $signed({2'b00, cur_bx}) - BH;
    assign b_xmax = $signed({2'b00, cur_bx}) + BH;
    assign b_ymin = $signed({2'b00, cur_by}) - BH;
    assign b_ymax = $signed({2'b00, cur_by}) + BH;

    assign cur_hit = snap_act[idx]
                   && (m_ymax >= b_ymin) && (m_ymin <= b_ymax)
                   && (m_xmax >= b_xmin) && (m_xmin <= b_xmax);

    // Working mask including the slot being tested this cycle
    always_comb begin
        mask_final      = work_mask;
        mask_final[idx] = cur_hit;
    end

    // Lowest set bit; scanning downward lets the lowest index win
    always_comb begin
        low_idx = '0;
        for (int i = NUM_BARRELS - 1; i >= 0; i--) begin
            if (mask_final[i]) low_idx = IDX_W'(i);
        end
    end

    // Snapshot, scan index and raw results
    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx       <= '0;
            work_mask <= '0;
            hit_mask  <= '0;
            hit_index <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    snap_mx   <= mario_x;
                    snap_my   <= mario_y;
                    snap_bx   <= barrel_x;
                    snap_by   <= barrel_y;
                    snap_act  <= barrel_active;
                    work_mask <= '0;
                    idx       <= '0;
                end
                SCAN: begin
                    work_mask <= mask_final;
                    if (last_slot) begin
                        hit_mask  <= mask_final;
                        hit_index <= low_idx;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef COLLISION_GRACE_EN
    localparam int GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
    logic [GW-1:0] grace_cnt;

    // A reported hit arms the counter; while it runs down, hits are masked.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            collision <= 1'b0;
            grace_cnt <= '0;
        end else if (enter_done) begin
            if (grace_cnt != '0) begin
                collision <= 1'b0;
                grace_cnt <= grace_cnt - 1'b1;
            end else if (|mask_final) begin
                collision <= 1'b1;
                grace_cnt <= GW'(GRACE_FRAMES);
            end else begin
                collision <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge Clk) begin
        if (Reset)           collision <= 1'b0;
        else if (enter_done) collision <= |mask_final;
    end
`endif

endmodule
